// File: rtl/des_ks_pkg.sv
// rtl/des_ks_pkg.sv - DES key schedule tables, state encoding and permutation helpers
package des_ks_pkg;

   localparam int HALF_W = 28;
   localparam int ROUNDS = 16;
   localparam int RK_W   = 48;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2,
      DONE  = 2'd3
   } ks_state_e;

   // Table entries use the DES convention: bit 1 is the MSB of the source word.
   localparam int PC1_TABLE [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TABLE [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam logic [1:0] SHIFT_TABLE [ROUNDS] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   function automatic logic [2*HALF_W-1:0] pc1(input logic [63:0] key);
      logic [2*HALF_W-1:0] r;
      r = '0;
      for (int i = 0; i < 2*HALF_W; i++)
         r[6'(2*HALF_W-1-i)] = key[6'(64-PC1_TABLE[i])];
      return r;
   endfunction

   function automatic logic [RK_W-1:0] pc2(input logic [2*HALF_W-1:0] cd);
      logic [RK_W-1:0] r;
      r = '0;
      for (int i = 0; i < RK_W; i++)
         r[6'(RK_W-1-i)] = cd[6'(2*HALF_W-PC2_TABLE[i])];
      return r;
   endfunction

   function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] v, input logic [1:0] amt);
      case (amt)
         2'd1:    return {v[HALF_W-2:0], v[HALF_W-1]};
         2'd2:    return {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
         default: return v;
      endcase
   endfunction

   function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] v, input logic [1:0] amt);
      case (amt)
         2'd1:    return {v[0], v[HALF_W-1:1]};
         2'd2:    return {v[1:0], v[HALF_W-1:2]};
         default: return v;
      endcase
   endfunction

endpackage

// File: rtl/des_ks_rot28.sv
// rtl/des_ks_rot28.sv - 28-bit rotate by 0/1/2, left when dir=0, right when dir=1
module des_ks_rot28
   import des_ks_pkg::*;
(
   input  logic [HALF_W-1:0] din,
   input  logic [1:0]        amt,
   input  logic              dir,
   output logic [HALF_W-1:0] dout
);

   assign dout = dir ? rotr28(din, amt) : rotl28(din, amt);

endmodule

// File: rtl/mux2_1.sv
// rtl/mux2_1.sv - two-input word multiplexer, in1 selected when sel is high
module mux2_1 #(
   parameter int W = 28
) (
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in0,
   input  logic         sel,
   output logic [W-1:0] y
);

   assign y = sel ? in1 : in0;

endmodule

// File: rtl/des_key_sched_ctrl.sv
// rtl/des_key_sched_ctrl.sv - DES key schedule sequencer issuing 16 PC-2 round keys over valid/ready
module des_key_sched_ctrl
   import des_ks_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            decrypt,
   input  logic [63:0]     key_in,
   output logic            busy,
   output logic            sel_load,
   output logic [RK_W-1:0] rk,
   output logic [3:0]      rk_idx,
   output logic            rk_valid,
   input  logic            rk_ready,
   output logic            done
);

   ks_state_e           state_q, state_d;
   logic [HALF_W-1:0]   c_q, d_q, c_rot, d_rot, c_nxt, d_nxt;
   logic [2*HALF_W-1:0] pc1_key;
   logic [3:0]          round_q;
   logic                mode_q;
   logic [1:0]          amt;
   logic                cd_en, hs, last_round;
   logic [RK_W-1:0]     rk_q;
   logic [3:0]          rk_idx_q;

   assign pc1_key    = pc1(key_in);
   assign last_round = (round_q == 4'(ROUNDS-1));
   // Decrypt starts from C16/D16, which equal C0/D0, so its first round needs no rotation.
   assign amt        = (mode_q && round_q == 4'd0) ? 2'd0 : SHIFT_TABLE[round_q];
   assign hs         = (state_q == OUT) && rk_ready;

   des_ks_rot28 u_rot_c (.din(c_q), .amt(amt), .dir(mode_q), .dout(c_rot));
   des_ks_rot28 u_rot_d (.din(d_q), .amt(amt), .dir(mode_q), .dout(d_rot));

   mux2_1 #(.W(HALF_W)) u_mux_c (.in1(pc1_key[2*HALF_W-1:HALF_W]), .in0(c_rot), .sel(sel_load), .y(c_nxt));
   mux2_1 #(.W(HALF_W)) u_mux_d (.in1(pc1_key[HALF_W-1:0]),        .in0(d_rot), .sel(sel_load), .y(d_nxt));

   always_comb begin
      state_d = state_q;
      cd_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cd_en   = 1'b1;
            end
         end
         SHIFT: begin
            state_d = OUT;
            cd_en   = 1'b1;
         end
         OUT: begin
            if (hs) state_d = last_round ? DONE : SHIFT;
         end
         DONE: state_d = IDLE;
      endcase
   end

   assign sel_load = (state_q == IDLE);
   assign busy     = (state_q == SHIFT) || (state_q == OUT);
   assign rk_valid = (state_q == OUT);
   assign done     = (state_q == DONE);
   assign rk       = rk_q;
   assign rk_idx   = rk_idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         c_q      <= '0;
         d_q      <= '0;
         round_q  <= '0;
         mode_q   <= 1'b0;
         rk_q     <= '0;
         rk_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (cd_en) begin
            c_q <= c_nxt;
            d_q <= d_nxt;
         end
         if (state_q == IDLE && start) begin
            mode_q  <= decrypt;
            round_q <= '0;
         end
         // Key is taken from the freshly rotated halves so it is ready on entry to OUT.
         if (state_q == SHIFT) begin
            rk_q     <= pc2({c_rot, d_rot});
            rk_idx_q <= mode_q ? 4'(ROUNDS-1) - round_q : round_q;
         end
         if (hs && !last_round) round_q <= round_q + 4'd1;
      end
   end

endmodule
